// File: rtl/serial_row_loader.sv
// Deserializes the bit-serial training stream on S into full data-point rows
// and writes one row per address into the SGD dataset memory.
module serial_row_loader #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = 15,
  parameter int LENGTH       = 16,
  parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  S,
  input  logic [3:0]            feat,
  input  logic [ADDR_WIDTH-1:0] data_points,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);
  localparam int BW = $clog2(LENGTH);
  localparam int FW = $clog2(MAX_FEATURES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t                state_q, state_d;
  logic [FW-1:0]         f_q, f_d;
  logic [FW-1:0]         word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0] dp_q, dp_d;
  logic [ADDR_WIDTH-1:0] row_cnt_q, row_cnt_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [LENGTH-1:0]     sr_q, sr_d;
  logic [LENGTH-1:0]     word;
  logic [DATA_WIDTH-1:0] row_q, row_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] row_full;
  logic                  wr_en_q, wr_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d    = state_q;
    f_d        = f_q;
    word_cnt_d = word_cnt_q;
    dp_d       = dp_q;
    row_cnt_d  = row_cnt_q;
    wr_addr_d  = wr_addr_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    row_d      = row_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    word       = {S, sr_q[LENGTH-1:1]};
    row_full   = row_q;
    row_full[LENGTH-1:0] = word;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = LOAD;
          f_d        = FW'(feat);
          dp_d       = data_points;
          bit_cnt_d  = '0;
          word_cnt_d = FW'(feat);
          row_cnt_d  = '0;
          row_d      = '0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
        end
      end
      LOAD: begin
        sr_d      = word;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BW'(LENGTH - 1)) begin
          bit_cnt_d = '0;
          if (word_cnt_q != '0) begin
            row_d[LENGTH*word_cnt_q +: LENGTH] = word;
            word_cnt_d = word_cnt_q - 1'b1;
          end else begin
            // Slot 0 closes the row: publish it and start the next row at once.
            wr_data_d  = row_full;
            wr_addr_d  = row_cnt_q;
            wr_en_d    = 1'b1;
            row_d      = '0;
            word_cnt_d = f_q;
            if (row_cnt_q == dp_q) begin
              state_d = FLUSH;
            end else begin
              row_cnt_d = row_cnt_q + 1'b1;
            end
          end
        end
      end
      FLUSH: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      f_q        <= '0;
      word_cnt_q <= '0;
      dp_q       <= '0;
      row_cnt_q  <= '0;
      wr_addr_q  <= '0;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      row_q      <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      f_q        <= f_d;
      word_cnt_q <= word_cnt_d;
      dp_q       <= dp_d;
      row_cnt_q  <= row_cnt_d;
      wr_addr_q  <= wr_addr_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      row_q      <= row_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/serial_row_loader.md
Name: serial_row_loader

Overview:
- Upstream input stage of the SGD datapath. Deserializes the single-bit training-data stream on `S` into full data-point rows.
- Writes each row into the dataset memory that the SGD core reads: one row per address, `DATA_WIDTH` bits wide.
- Stream order: rows 0..`data_points`. Within a row, words run from index `feat` down to 0. Each 16-bit word arrives LSB first.
- Signals completion to the SGD controller so training can begin.

Parameters:
- ADDR_WIDTH, 12, width of row address and of `data_points`.
- MAX_FEATURES, 15, maximum feature count; row holds MAX_FEATURES+1 words (features plus y).
- LENGTH, 16, bits per word.
- DATA_WIDTH, LENGTH*(MAX_FEATURES+1), row width written to memory.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- S  in  1  serial data bit, sampled every rising CLK edge while in LOAD.
- feat  in  4  highest word index per row (words per row = feat+1); latched on start.
- data_points  in  ADDR_WIDTH  highest row index (rows loaded = data_points+1); latched on start.
- wr_en  out  1  one-cycle memory write strobe.
- wr_addr  out  ADDR_WIDTH  row address for the write.
- wr_data  out  DATA_WIDTH  assembled row; word j occupies bits [LENGTH*j +: LENGTH].
- busy  out  1  high from the cycle after start until the final write cycle, inclusive.
- done  out  1  sticky load-complete flag.

Behaviour:
- Reset (RST=1 at a rising edge):
  - State returns to IDLE.
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
  - All counters, the shift register and the row buffer clear.
  - RST overrides every other input.
  - RST mid-LOAD abandons the partial row with no write issued.
- States:
  - IDLE: start=1 → LOAD. Latch feat into f_r and data_points into dp_r. Set bit_cnt=0, word_cnt=feat, row_cnt=0. Clear the row buffer. Clear done.
  - LOAD: sample S on every edge with no gaps. The first bit is sampled on the edge after the start edge.
    - Shift: sr <= {S, sr[LENGTH-1:1]}; bit_cnt increments.
    - On the edge sampling bit LENGTH-1: the completed word {S, sr[LENGTH-1:1]} goes into row buffer slot word_cnt; bit_cnt wraps to 0.
    - If word_cnt > 0: decrement word_cnt.
    - If word_cnt == 0: load the full row (including the word just completed) into wr_data; set wr_addr=row_cnt. Drive wr_en=1 in the following cycle, for exactly one cycle.
    - After a row completes: clear the row buffer and reload word_cnt=f_r.
    - If row_cnt == dp_r → DONE; otherwise increment row_cnt.
    - Sampling of the next row starts on the very next edge. A write and the next row's first bit occur in the same cycle.
  - DONE: done=1, held until RST or a new start.
    - done rises in the cycle after the final wr_en.
    - busy falls together with that final wr_en cycle.
    - start in DONE behaves exactly as start in IDLE.
- Row content:
  - Slots j > f_r are written as zero.
  - wr_data is held stable between writes. It is valid only while wr_en=1.
- start while in LOAD is ignored.
- Widths and timing:
  - row_cnt is ADDR_WIDTH wide. data_points = 2^ADDR_WIDTH-1 loads every address with no wrap.
  - feat=0 gives single-word rows: one write every LENGTH cycles.
  - Total load length = (dp_r+1)*(f_r+1)*LENGTH sampled bits.
  - Final wr_en falls 1 cycle after the last bit edge.

Test Plan:
- Single row. feat=1, data_points=0, start. Stream 0xABCD then 0x1234, LSB first (32 bits).
  - wr_en pulses once, 1 cycle after bit 32 is sampled.
  - wr_addr=0; wr_data[31:0]=0xABCD1234; upper bits 0.
  - done=1 on the next cycle; busy=0.
- Multi-row back-to-back. feat=5, data_points=5; 36 words with word value = 16*row + index.
  - Exactly 6 writes, at addresses 0..5, spaced 96 cycles apart.
  - Each row's slot j holds 16*row + j.
  - No bit is lost across row boundaries.
- Reset mid-load. feat=2, data_points=3; assert RST after 40 bits.
  - No wr_en; all outputs 0; state IDLE.
  - A subsequent start with feat=0, data_points=0 and the word 0x00FF writes 0x00FF to address 0 with upper bits 0.
- Ignored and restart start. Pulse start during LOAD at bit 10: no effect, and the write sequence is unchanged.
  - After DONE, a second start with new feat/data_points clears done, reloads from address 0, and uses the new values.
- Full width. feat=15, data_points=1; every word 0xFFFF.
  - 2 writes, each with wr_data all ones (256 bits), at addresses 0 and 1.
- Minimum word count. feat=0, data_points=2; words 0x0001, 0x8000, 0xFFFF.
  - Writes every 16 cycles to addresses 0, 1, 2 with wr_data[15:0] equal to those words respectively.
